// File: rtl/ram_dp_sync.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// After reset a hardware sequence clears every word before the ports are accepted.
module ram_dp_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 128,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable in the range compare.
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                init_busy_q, init_busy_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic                wr_err_q, wr_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic                wr_ok_s;
  logic                rd_ok_s;

  assign wr_ok_s = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok_s = ({1'b0, rd_addr} < DEPTH_L);

  // Clear-sequence FSM: walk every address once, then stay in RUN until reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    case (state_q)
      ST_INIT: begin
        init_busy_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_busy_d = 1'b0;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_d     = ST_RUN;
        init_busy_d = 1'b0;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  // Memory write port arbitration: the clear sequence owns the port during INIT.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (!rst_n) begin
      mem_we_s = 1'b0;
    end else if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
    end else if (wr_en && wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr[IDX_W-1:0];
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Read result and error flags for the next cycle; rd_data holds when no read is issued.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    if (state_q == ST_RUN) begin
      wr_err_d = wr_en && !wr_ok_s;
      if (rd_en) begin
        rd_valid_d = 1'b1;
        if (!rd_ok_s) begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
        end else if ((BYPASS == 1'b1) && wr_en && wr_ok_s && (wr_addr == rd_addr)) begin
          rd_data_d = wr_data;
        end else begin
          rd_data_d = mem_q[rd_addr[IDX_W-1:0]];
        end
      end else begin
        rd_valid_d = 1'b0;
      end
    end else begin
      wr_err_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Storage array; contents are cleared by the INIT walk, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign init_busy = init_busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Scoreboard bench for ram_dp_sync: stimulus pushes expected read/write-error results,
// a monitor pops them whenever the DUT presents rd_valid or wr_err.
module tb_ram_dp_sync;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 128;
  localparam bit BYPASS = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              init_busy;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_err;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  ram_dp_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  int                n_checks = 0;
  int                n_fail = 0;
  int                valid_seen = 0;
  bit                mon_en = 1'b0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  rd_exp_t           rd_q [$];
  bit                wr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes one expectation per rd_valid / wr_err pulse.
  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rd_valid === 1'b1) begin
          valid_seen++;
          check("rd_valid_expected", 32'(rd_q.size() > 0), 32'd1);
          if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e.data));
            check("rd_err", 32'(rd_err), 32'(e.err));
          end
        end else if (rd_err !== 1'b0) begin
          check("rd_err_without_valid", 32'(rd_err), 32'd0);
        end
        if (wr_err === 1'b1) begin
          check("wr_err_expected", 32'(wr_q.size() > 0), 32'd1);
          if (wr_q.size() > 0) void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // One RUN-mode cycle: drive inputs and record what the memory must answer.
  task automatic op(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                    input bit re, input logic [ADDR_W-1:0] ra);
    rd_exp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re) begin
      if (ra >= DEPTH) e = '{err: 1'b1, data: '0};
      else if (BYPASS && we && wa == ra) e = '{err: 1'b0, data: wd};
      else e = '{err: 1'b0, data: ref_mem[ra]};
      rd_q.push_back(e);
    end
    if (we) begin
      if (wa < DEPTH) ref_mem[wa] = wd;
      else wr_q.push_back(1'b1);
    end
  endtask

  // Async reset mid-cycle, then watch the clear sequence (cut > 0 aborts it after cut cycles).
  task automatic reset_seq(input int cut);
    int k;
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("rst_wr_q_empty", 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_hold_init_busy", 32'(init_busy), 32'd1);
    rst_n = 1'b1;
    k = 0;
    // Random port activity during INIT must be ignored.
    while (init_busy === 1'b1 && k < 4 * DEPTH && (cut == 0 || k < cut)) begin
      wr_en   = 1'($urandom);
      wr_addr = 16'($urandom_range(0, 255));
      wr_data = 16'($urandom);
      rd_en   = 1'($urandom);
      rd_addr = 16'($urandom_range(0, 255));
      @(negedge clk);
      k++;
    end
    idle_inputs();
    if (cut == 0) check("init_cycles", 32'(k), 32'(DEPTH));
    else check("init_busy_mid", 32'(init_busy), 32'd1);
  endtask

  localparam logic [DATA_W-1:0] T3_EXP = BYPASS ? 16'h1234 : 16'hAAAA;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int v0;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // 1: reset, clear sequence, whole memory reads zero
    reset_seq(0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, '0, 1'b1, 16'(i));

    // 2: write then read back
    op(1'b1, 16'd5, 16'hBEEF, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 16'd5);
    @(posedge clk); #1;
    check("t2_data", 32'(rd_data), 32'h0000BEEF);
    check("t2_valid", 32'(rd_valid), 32'd1);

    // 3: same-edge read and write to one address
    op(1'b1, 16'd9, 16'hAAAA, 1'b0, '0);
    op(1'b1, 16'd9, 16'h1234, 1'b1, 16'd9);
    @(posedge clk); #1;
    check("t3_rdw", 32'(rd_data), 32'(T3_EXP));
    op(1'b0, '0, '0, 1'b1, 16'd9);

    // 4: out-of-range write and read, including an address that would alias if upper bits were dropped
    op(1'b1, 16'd128, 16'h5555, 1'b0, '0);
    @(posedge clk); #1;
    check("t4_wr_err", 32'(wr_err), 32'd1);
    op(1'b1, 16'h8005, 16'hDEAD, 1'b1, 16'hFFFF);
    @(posedge clk); #1;
    check("t4_rd_err", 32'(rd_err), 32'd1);
    check("t4_rd_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, '0, 1'b1, 16'(i));

    // 5: streaming writes then reads, one per cycle
    for (int i = 0; i < DEPTH; i++) op(1'b1, 16'(i), 16'($urandom), 1'b0, '0);
    v0 = valid_seen;
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, '0, 1'b1, 16'(i));
    op(1'b0, '0, '0, 1'b0, '0);
    op(1'b0, '0, '0, 1'b0, '0);
    check("t5_valid_count", 32'(valid_seen - v0), 32'(DEPTH));

    // Random mix with occasional out-of-range addresses and forced address collisions
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
      b = ($urandom_range(0, 3) == 0) ? a :
          (($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1)));
      op(1'($urandom), a, 16'($urandom), 1'($urandom), b);
    end

    // 6: reset during RUN with rd_data non-zero, reset during INIT, then full clear
    op(1'b1, 16'd5, 16'hBEEF, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 16'd5);
    reset_seq(0);
    reset_seq(40);
    reset_seq(0);
    op(1'b0, '0, '0, 1'b1, 16'd5);
    @(posedge clk); #1;
    check("t6_cleared", 32'(rd_data), 32'd0);
    check("t6_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, '0, 1'b1, 16'(i));

    op(1'b0, '0, '0, 1'b0, '0);
    op(1'b0, '0, '0, 1'b0, '0);
    check("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
